key_debounce_dual: RTL and testbench

- Dual-channel push-button conditioner; sits directly upstream of the dual JK flip-flop chip model.
- Each channel takes a raw, bouncing, active-low key and produces a clean level (KOUT1/KOUT2) wired to the flip-flop CLK1/CLK2 pins.
- One key press therefore produces exactly one falling clock edge on the flip-flop (single-step lab operation).
- Also produces one-cycle press/release pulses for counters and LEDs.

---
 rtl/key_debounce_dual.sv | 172 +++++++++++++++++
 tb/tb_key_debounce_dual.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_dual.sv
// key_debounce_dual: two independent push-button conditioners.
//
// Each channel takes a raw, bouncing, active-low key and produces a clean
// level that is safe to use as a clock pin of a downstream flip-flop. It also
// produces one-cycle pulses on accepted press and release. One press yields
// exactly one falling edge on KOUTn.
//
// Ports:
//   CLK          system clock, all logic on the rising edge
//   RST          synchronous, active-high reset
//   KEY1, KEY2   raw keys (asynchronous, active-low, idle high)
//   KOUT1, KOUT2 debounced levels (idle high, low while pressed)
//   KNEG1, KNEG2 one-cycle pulse when KOUTn goes 1->0 (accepted press)
//   KPOS1, KPOS2 one-cycle pulse when KOUTn goes 0->1 (accepted release)
//
// Parameters:
//   DEB_CYCLES   consecutive cycles a new synchronized level must persist
//                before it is accepted (>= 2)
//   CW           counter width, 2**CW >= DEB_CYCLES

module key_debounce_chan #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CW         = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic kout,
  output logic kneg,
  output logic kpos
);

  typedef enum logic [1:0] {
    IDLE_HI,
    CNT_LO,
    IDLE_LO,
    CNT_HI
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          kout_nxt, kneg_nxt, kpos_nxt;
  logic          sync0, sync1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
      state <= IDLE_HI;
      cnt   <= '0;
      kout  <= 1'b1;
      kneg  <= 1'b0;
      kpos  <= 1'b0;
    end else begin
      // synchronizer stage: only sync1 is trusted downstream
      sync0 <= key;
      sync1 <= sync0;
      // debounce stage
      state <= state_nxt;
      cnt   <= cnt_nxt;
      kout  <= kout_nxt;
      kneg  <= kneg_nxt;
      kpos  <= kpos_nxt;
    end
  end

  // The counter is seeded with 1 on the first cycle of a new level, so the
  // acceptance compare at DEB_CYCLES-1 fires on the DEB_CYCLES-th
  // consecutive synchronized cycle. Any reversion restarts from zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    kout_nxt  = kout;
    kneg_nxt  = 1'b0;
    kpos_nxt  = 1'b0;
    case (state)
      IDLE_HI: begin
        if (!sync1) begin
          state_nxt = CNT_LO;
          cnt_nxt   = CW'(1);
        end else begin
          cnt_nxt   = '0;
        end
      end
      CNT_LO: begin
        if (sync1) begin
          state_nxt = IDLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LO;
          cnt_nxt   = '0;
          kout_nxt  = 1'b0;
          kneg_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt + CW'(1);
        end
      end
      IDLE_LO: begin
        if (sync1) begin
          state_nxt = CNT_HI;
          cnt_nxt   = CW'(1);
        end else begin
          cnt_nxt   = '0;
        end
      end
      CNT_HI: begin
        if (!sync1) begin
          state_nxt = IDLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HI;
          cnt_nxt   = '0;
          kout_nxt  = 1'b1;
          kpos_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE_HI;
        cnt_nxt   = '0;
        kout_nxt  = 1'b1;
      end
    endcase
  end

endmodule

module key_debounce_dual #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CW         = 20
) (
  input  logic CLK,
  input  logic RST,
  input  logic KEY1,
  input  logic KEY2,
  output logic KOUT1,
  output logic KOUT2,
  output logic KNEG1,
  output logic KNEG2,
  output logic KPOS1,
  output logic KPOS2
);

  // Channels share nothing but clock and reset.
  key_debounce_chan #(
    .DEB_CYCLES (DEB_CYCLES),
    .CW         (CW)
  ) u_ch1 (
    .clk  (CLK),
    .rst  (RST),
    .key  (KEY1),
    .kout (KOUT1),
    .kneg (KNEG1),
    .kpos (KPOS1)
  );

  key_debounce_chan #(
    .DEB_CYCLES (DEB_CYCLES),
    .CW         (CW)
  ) u_ch2 (
    .clk  (CLK),
    .rst  (RST),
    .key  (KEY2),
    .kout (KOUT2),
    .kneg (KNEG2),
    .kpos (KPOS2)
  );

endmodule

// File: tb/tb_key_debounce_dual.sv
// Bench for key_debounce_dual with DEB_CYCLES=4. Expected pulse cycles are
// pushed into per-output queues when key stimulus is driven and are popped
// by a monitor when the DUT raises a pulse.
module tb_key_debounce_dual;

  localparam int DEB = 4;
  localparam int CW  = 3;
  // Key driven after edge n (i.e. before edge n+1): output changes after
  // edge n+1+1+DEB.
  localparam int LAT = 2 + DEB;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic KEY1 = 1'b1;
  logic KEY2 = 1'b1;
  logic KOUT1, KOUT2, KNEG1, KNEG2, KPOS1, KPOS2;

  key_debounce_dual #(
    .DEB_CYCLES (DEB),
    .CW         (CW)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .KEY1  (KEY1),
    .KEY2  (KEY2),
    .KOUT1 (KOUT1),
    .KOUT2 (KOUT2),
    .KNEG1 (KNEG1),
    .KNEG2 (KNEG2),
    .KPOS1 (KPOS1),
    .KPOS2 (KPOS2)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // 0:KNEG1 1:KPOS1 2:KNEG2 3:KPOS2
  int    q[4][$];
  string nm[4] = '{"KNEG1", "KPOS1", "KNEG2", "KPOS2"};
  bit    mon_en = 1'b0;
  logic  prev1 = 1'b1;
  logic  prev2 = 1'b1;

  // Downstream JK flip-flop, J=K=1, clocked on the falling edge of KOUT1.
  logic jk_q = 1'b0;
  int   jk_toggles = 0;
  always @(negedge KOUT1) begin
    if (mon_en) begin
      jk_q       <= ~jk_q;
      jk_toggles <= jk_toggles + 1;
    end
  end

  // Pulse monitor / scoreboard
  always @(posedge CLK) begin : mon
    logic [3:0] p;
    int         exp_c;
    #1;
    p = {KPOS2, KNEG2, KPOS1, KNEG1};
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        if (p[i]) begin
          checks++;
          if (q[i].size() == 0) begin
            errors++;
            $display("FAIL %s unexpected pulse at cycle %0d (none expected)", nm[i], cyc);
          end else begin
            exp_c = q[i].pop_front();
            if (cyc !== exp_c) begin
              errors++;
              $display("FAIL %s pulse at cycle %0d, expected cycle %0d", nm[i], cyc, exp_c);
            end
          end
        end else if (q[i].size() != 0 && q[i][0] < cyc) begin
          checks++;
          errors++;
          exp_c = q[i].pop_front();
          $display("FAIL %s missing pulse: none by cycle %0d, expected cycle %0d", nm[i], cyc, exp_c);
        end
      end
      checks++;
      if ((((prev1 & ~KOUT1) !== KNEG1) || ((~prev1 & KOUT1) !== KPOS1))) begin
        errors++;
        $display("FAIL ch1_edge_pulse cycle %0d: KOUT1 %b->%b KNEG1=%b KPOS1=%b", cyc, prev1, KOUT1, KNEG1, KPOS1);
      end
      checks++;
      if ((((prev2 & ~KOUT2) !== KNEG2) || ((~prev2 & KOUT2) !== KPOS2))) begin
        errors++;
        $display("FAIL ch2_edge_pulse cycle %0d: KOUT2 %b->%b KNEG2=%b KPOS2=%b", cyc, prev2, KOUT2, KNEG2, KPOS2);
      end
    end
    prev1 = KOUT1;
    prev2 = KOUT2;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    RST  = 1'b1;
    KEY1 = 1'b0;
    KEY2 = 1'b1;
    tick(3);
    mon_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      checks++;
      if ({KOUT1, KOUT2, KNEG1, KPOS1, KNEG2, KPOS2} !== 6'b110000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: outs=%b expected 110000", cyc,
                 {KOUT1, KOUT2, KNEG1, KPOS1, KNEG2, KPOS2});
      end
    end
    KEY1 = 1'b1;
    RST  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      checks++;
      if ({KOUT1, KOUT2, KNEG1, KPOS1, KNEG2, KPOS2} !== 6'b110000) begin
        errors++;
        $display("FAIL reset_release cycle %0d: outs=%b expected 110000", cyc,
                 {KOUT1, KOUT2, KNEG1, KPOS1, KNEG2, KPOS2});
      end
    end
  endtask

  task automatic test_clean_press();
    int n, m;
    n = cyc;
    KEY1 = 1'b0;
    q[0].push_back(n + LAT);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (cyc == n + LAT - 1) begin
        checks++;
        if (KOUT1 !== 1'b1) begin
          errors++;
          $display("FAIL press_early KOUT1=%b expected 1 at cycle %0d", KOUT1, cyc);
        end
      end
      if (cyc == n + LAT) begin
        checks++;
        if ({KOUT1, KNEG1} !== 2'b01) begin
          errors++;
          $display("FAIL press_edge KOUT1,KNEG1=%b expected 01 at cycle %0d", {KOUT1, KNEG1}, cyc);
        end
      end
      if (cyc == n + LAT + 1) begin
        checks++;
        if ({KOUT1, KNEG1} !== 2'b00) begin
          errors++;
          $display("FAIL press_after KOUT1,KNEG1=%b expected 00 at cycle %0d", {KOUT1, KNEG1}, cyc);
        end
      end
      checks++;
      if ({KOUT2, KNEG2, KPOS2, KPOS1} !== 4'b1000) begin
        errors++;
        $display("FAIL press_ch2_quiet KOUT2,KNEG2,KPOS2,KPOS1=%b expected 1000 at cycle %0d",
                 {KOUT2, KNEG2, KPOS2, KPOS1}, cyc);
      end
    end
    m = cyc;
    KEY1 = 1'b1;
    q[1].push_back(m + LAT);
    tick(10);
    checks++;
    if (KOUT1 !== 1'b1) begin
      errors++;
      $display("FAIL press_release KOUT1=%b expected 1", KOUT1);
    end
  endtask

  task automatic test_bounce();
    int n, m;
    for (int seg = 0; seg < 4; seg++) begin
      KEY1 = (seg % 2 == 1);
      for (int k = 0; k < 2; k++) begin
        tick(1);
        checks++;
        if ({KOUT1, KNEG1} !== 2'b10) begin
          errors++;
          $display("FAIL bounce_hold KOUT1,KNEG1=%b expected 10 at cycle %0d", {KOUT1, KNEG1}, cyc);
        end
      end
    end
    n = cyc;
    KEY1 = 1'b0;
    q[0].push_back(n + LAT);
    for (int k = 0; k < 12; k++) begin
      tick(1);
      checks++;
      if (KOUT1 !== ((cyc >= n + LAT) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL bounce_settle KOUT1=%b at cycle %0d (stable low from cycle %0d)", KOUT1, cyc, n);
      end
    end
    m = cyc;
    KEY1 = 1'b1;
    q[1].push_back(m + LAT);
    tick(10);
  endtask

  task automatic test_boundary_glitch();
    int n;
    KEY2 = 1'b0;
    tick(DEB - 1);
    KEY2 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      checks++;
      if ({KOUT2, KNEG2, KPOS2} !== 3'b100) begin
        errors++;
        $display("FAIL glitch_short KOUT2,KNEG2,KPOS2=%b expected 100 at cycle %0d", {KOUT2, KNEG2, KPOS2}, cyc);
      end
    end
    n = cyc;
    KEY2 = 1'b0;
    q[2].push_back(n + LAT);
    tick(DEB);
    KEY2 = 1'b1;
    q[3].push_back(n + DEB + LAT);
    for (int k = 0; k < 12; k++) begin
      tick(1);
      checks++;
      if (KOUT2 !== ((cyc >= n + LAT && cyc < n + DEB + LAT) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL glitch_exact KOUT2=%b at cycle %0d (low window %0d..%0d)", KOUT2, cyc,
                 n + LAT, n + DEB + LAT - 1);
      end
    end
  endtask

  task automatic test_simultaneous();
    int n, m;
    n = cyc;
    KEY1 = 1'b0;
    KEY2 = 1'b0;
    q[0].push_back(n + LAT);
    q[2].push_back(n + LAT);
    tick(LAT);
    checks++;
    if ({KOUT1, KOUT2, KNEG1, KNEG2} !== 4'b0011) begin
      errors++;
      $display("FAIL simul_press KOUT1,KOUT2,KNEG1,KNEG2=%b expected 0011", {KOUT1, KOUT2, KNEG1, KNEG2});
    end
    tick(4);
    m = cyc;
    KEY1 = 1'b1;
    q[1].push_back(m + LAT);
    tick(3);
    KEY2 = 1'b1;
    q[3].push_back(m + 3 + LAT);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (cyc == m + LAT) begin
        checks++;
        if ({KPOS1, KPOS2, KOUT1, KOUT2} !== 4'b1010) begin
          errors++;
          $display("FAIL simul_rel1 KPOS1,KPOS2,KOUT1,KOUT2=%b expected 1010", {KPOS1, KPOS2, KOUT1, KOUT2});
        end
      end
      if (cyc == m + 3 + LAT) begin
        checks++;
        if ({KPOS1, KPOS2, KOUT1, KOUT2} !== 4'b0111) begin
          errors++;
          $display("FAIL simul_rel2 KPOS1,KPOS2,KOUT1,KOUT2=%b expected 0111", {KPOS1, KPOS2, KOUT1, KOUT2});
        end
      end
    end
    tick(4);
  endtask

  task automatic test_reset_mid_count();
    int r, m;
    KEY1 = 1'b0;
    tick(4);
    RST = 1'b1;
    tick(1);
    checks++;
    if ({KOUT1, KNEG1, KPOS1} !== 3'b100) begin
      errors++;
      $display("FAIL midrst_reset KOUT1,KNEG1,KPOS1=%b expected 100", {KOUT1, KNEG1, KPOS1});
    end
    RST = 1'b0;
    r = cyc;
    q[0].push_back(r + LAT);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      checks++;
      if (KOUT1 !== ((cyc >= r + LAT) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL midrst_restart KOUT1=%b at cycle %0d (fall expected at %0d)", KOUT1, cyc, r + LAT);
      end
    end
    m = cyc;
    KEY1 = 1'b1;
    q[1].push_back(m + LAT);
    tick(10);
  endtask

  task automatic test_downstream();
    int   t0, n;
    logic q0;
    t0 = jk_toggles;
    q0 = jk_q;
    for (int p = 0; p < 3; p++) begin
      n = cyc;
      KEY1 = 1'b0;
      q[0].push_back(n + LAT);
      tick(8);
      n = cyc;
      KEY1 = 1'b1;
      q[1].push_back(n + LAT);
      tick(8);
    end
    checks++;
    if (jk_toggles - t0 !== 3) begin
      errors++;
      $display("FAIL jk_toggles got %0d expected 3", jk_toggles - t0);
    end
    checks++;
    if (jk_q !== ~q0) begin
      errors++;
      $display("FAIL jk_q got %b expected %b", jk_q, ~q0);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_boundary_glitch();
    test_simultaneous();
    test_reset_mid_count();
    test_downstream();
    tick(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q[i].size() != 0) begin
        errors++;
        $display("FAIL %s leftover expected pulses: %0d remaining, expected 0", nm[i], q[i].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
